diff_scan_ctrl: RTL and testbench
=================================

Name: diff_scan_ctrl

Overview:
Multi-cycle sequencer for the KGP_RISC diff operation, shared by two requesters (0 = execute stage, 1 = debug/self-test port).
- Arbitrates between the requesters round-robin and latches the granted operand pair.
- Scans a XOR b from the LSB, CHUNK bits per cycle, and reports the index of the least-significant differing bit plus a zero flag.
- Lets the core trade diff latency for area in place of the single-cycle combinational diff unit.

Parameters:
WIDTH, 32, operand width; must be a multiple of CHUNK and no greater than 64
CHUNK, 4, bits examined per SCAN cycle; power of two, 1..WIDTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operand pair
req0_a  input  WIDTH  requester 0 operand a
req0_b  input  WIDTH  requester 0 operand b
req0_ready  output  1  requester 0 accepted this cycle
req1_valid  input  1  requester 1 has an operand pair
req1_a  input  WIDTH  requester 1 operand a
req1_b  input  WIDTH  requester 1 operand b
req1_ready  output  1  requester 1 accepted this cycle
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes the result
rsp_id  output  1  requester that owns the result
rsp_pos  output  6  index of the LSB where a and b differ
rsp_zero  output  1  a == b
busy  output  1  state != IDLE

Behaviour:
- Reset:
  - clk and rst are the only clock and reset; rst is asynchronous and active-high.
  - Reset forces state=IDLE and last_grant=1, so requester 0 wins first.
  - Reset clears: idx=0, rsp_valid=0, rsp_id=0, rsp_pos=0, rsp_zero=0, busy=0, both ready outputs=0.
- States: IDLE, SCAN, RESP.
- IDLE:
  - reqN_ready is combinational and is high only for the granted requester with valid high.
  - Grant rule: if only one requester is valid, grant it. If both are valid, grant the one that is not last_grant.
  - On an accept edge, register x = a XOR b, set id = grant, last_grant = grant, idx = 0, and go to SCAN.
  - The block must not accept a request in any state other than IDLE.
- SCAN:
  - Each cycle examines x[idx+CHUNK-1 : idx].
  - If any bit is set: rsp_pos = idx + (lowest set bit within the chunk), rsp_zero = 0, go to RESP.
  - Otherwise, if idx + CHUNK == WIDTH: rsp_pos = 0, rsp_zero = 1, go to RESP.
  - Otherwise idx += CHUNK.
- Latency:
  - If accept happens at edge E0, rsp_valid rises after edge E0+k.
  - k = floor(pos/CHUNK) + 1 when the operands differ; k = WIDTH/CHUNK when they are equal.
  - With defaults, k ranges 1..8.
- RESP:
  - rsp_valid=1. rsp_id, rsp_pos and rsp_zero stay stable until rsp_ready is high at a rising edge.
  - On that handshake edge: rsp_valid=0 and go to IDLE.
  - A new accept is possible at the earliest on the edge after the handshake edge, i.e. no same-cycle back-to-back accept.
- rsp_pos is zero-extended to 6 bits.
- A requester that drops valid before it is accepted loses nothing; the arbiter re-evaluates every IDLE cycle.
- Operand inputs are sampled only on the accept edge. Later input changes do not affect the operation in flight.
- Reset asserted mid-SCAN or mid-RESP aborts the operation immediately (asynchronously). No response is emitted for the aborted request.

Test Plan:
1. Requester 0 alone, a=0x00000140, b=0x000000C0 (x=0x180) -> after 2 SCAN cycles: rsp_valid=1, rsp_id=0, rsp_pos=7, rsp_zero=0.
2. Requester 1, a=0x80000000, b=0 -> after 8 SCAN cycles: rsp_pos=31, rsp_zero=0, rsp_id=1. Then a=1, b=2 -> after 1 SCAN cycle: rsp_pos=0, rsp_zero=0.
3. Equal operands, a=b=0xDEADBEEF -> after 8 SCAN cycles: rsp_zero=1, rsp_pos=0.
4. Both requesters valid continuously from reset with distinct operands -> grants in order 0,1,0,1, with rsp_id matching. The ready outputs are never high together, and never high outside IDLE.
5. Hold rsp_ready=0 for 5 cycles after rsp_valid rises -> outputs stay frozen and busy=1. req0_ready stays 0 even with req0_valid=1. Release -> handshake, then the pending request is accepted on the next edge.
6. Assert rst during cycle 3 of an 8-cycle scan -> all outputs go to 0 immediately and no rsp_valid pulse appears. After deassert, the first grant goes to requester 0.

Source files
------------

// File: rtl/diff_scan_ctrl.sv
// rtl/diff_scan_ctrl.sv - round-robin shared diff sequencer scanning a^b CHUNK bits per cycle
module diff_scan_ctrl #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [5:0]       rsp_pos,
    output logic             rsp_zero,
    output logic             busy
);

    localparam int IW = 7;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - CHUNK);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t           state;
    logic [WIDTH-1:0] x;
    logic [IW-1:0]    idx;
    logic             last_grant;

    logic             grant;
    logic             can_accept;
    logic [CHUNK-1:0] chunk;
    logic [IW-1:0]    low_bit;
    logic             hit;

    // Ready is gated by rst so nothing is handed out while the block is held in reset.
    always_comb begin
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else
            grant = req1_valid;
        can_accept = (state == IDLE) && !rst && (req0_valid || req1_valid);
        req0_ready = can_accept && !grant;
        req1_ready = can_accept && grant;
    end

    always_comb begin
        chunk   = CHUNK'(x >> idx);
        hit     = |chunk;
        low_bit = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (chunk[i])
                low_bit = IW'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            idx        <= '0;
            x          <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_pos    <= '0;
            rsp_zero   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (can_accept) begin
                        x          <= grant ? (req1_a ^ req1_b) : (req0_a ^ req0_b);
                        rsp_id     <= grant;
                        last_grant <= grant;
                        idx        <= '0;
                        busy       <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        rsp_pos   <= 6'(idx + low_bit);
                        rsp_zero  <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (idx == LAST_IDX) begin
                        rsp_pos   <= '0;
                        rsp_zero  <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        idx <= idx + IW'(CHUNK);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_diff_scan_ctrl.sv
// tb/tb_diff_scan_ctrl.sv - scoreboard bench for diff_scan_ctrl
module tb_diff_scan_ctrl;

    localparam int W = 32;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_id, rsp_zero, busy;
    logic         rsp_ready = 1'b0;
    logic [5:0]   rsp_pos;

    diff_scan_ctrl #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_pos(rsp_pos), .rsp_zero(rsp_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit id;
        int pos;
        bit zero;
        int e0;
        int k;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   outstanding = 0;
    bit   tb_last = 1;
    bit   in_resp = 0;
    bit   stall_req = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: lowest differing bit of a^b, latency from the chunk that holds it.
    function automatic exp_t model(bit id, logic [W-1:0] a, logic [W-1:0] b, int e0);
        exp_t e;
        logic [W-1:0] x;
        x      = a ^ b;
        e.id   = id;
        e.e0   = e0;
        e.zero = (x == '0);
        e.pos  = 0;
        e.k    = W / C;
        if (x != '0) begin
            for (int i = W - 1; i >= 0; i--)
                if (x[i]) e.pos = i;
            e.k = e.pos / C + 1;
        end
        return e;
    endfunction

    task automatic gen(output logic [W-1:0] a, output logic [W-1:0] b);
        a = $urandom;
        case ($urandom_range(0, 3))
            0: b = a;
            1: b = a ^ (32'h1 << $urandom_range(0, W - 1));
            2: b = a ^ ($urandom << $urandom_range(0, W - 1));
            default: b = $urandom;
        endcase
    endtask

    task automatic drive_cycle(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                               output bit acc);
        bit exp_any, exp_g;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        #1;
        chk("busy", busy, outstanding);
        exp_any = !outstanding && (v0 || v1);
        exp_g   = (v0 && v1) ? !tb_last : v1;
        chk("req0_ready", req0_ready, exp_any && !exp_g);
        chk("req1_ready", req1_ready, exp_any && exp_g);
        acc = 0;
        if (req0_ready && v0) begin
            sb.push_back(model(0, a0, b0, cyc + 1));
            tb_last = 0; outstanding = 1; acc = 1;
        end else if (req1_ready && v1) begin
            sb.push_back(model(1, a1, b1, cyc + 1));
            tb_last = 1; outstanding = 1; acc = 1;
        end
    endtask

    task automatic send(input bit who, input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc = 0;
        for (int n = 0; n < 200 && !acc; n++)
            drive_cycle(!who, a, b, who, a, b, acc);
        if (!acc) chk("send_timeout", 1, 0);
    endtask

    task automatic idle_cycles(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive_cycle(0, '0, '0, 0, '0, '0, acc);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_pos"}, rsp_pos, 0);
        chk({tag, "_rsp_zero"}, rsp_zero, 0);
        chk({tag, "_ready0"}, req0_ready, 0);
        chk({tag, "_ready1"}, req1_ready, 0);
    endtask

    // Monitor: pops the scoreboard when a response first appears, holds it stable until handshake.
    initial begin : monitor
        exp_t cur;
        logic [5:0] h_pos;
        logic h_id, h_zero;
        int hold = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                in_resp = 0; rsp_ready = 0; hold = 0;
                continue;
            end
            if (req0_ready && req1_ready) chk("ready_both", 1, 0);
            if (rsp_valid) begin
                if (!in_resp) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        cur = sb.pop_front();
                        chk("rsp_id", rsp_id, cur.id);
                        chk("rsp_pos", rsp_pos, cur.pos);
                        chk("rsp_zero", rsp_zero, cur.zero);
                        chk("latency", cyc - cur.e0, cur.k);
                    end
                    h_id = rsp_id; h_pos = rsp_pos; h_zero = rsp_zero;
                    in_resp = 1;
                    if (stall_req) begin hold = 5; stall_req = 0; end
                end else begin
                    chk("hold_id", rsp_id, h_id);
                    chk("hold_pos", rsp_pos, h_pos);
                    chk("hold_zero", rsp_zero, h_zero);
                end
                chk("resp_busy", busy, 1);
                if (hold > 0) begin
                    rsp_ready = 0;
                    hold--;
                end else begin
                    rsp_ready = ($urandom_range(0, 99) < 55);
                end
                if (rsp_ready) begin
                    in_resp = 0;
                    outstanding = 0;
                end
            end else begin
                rsp_ready = $urandom_range(0, 1);
            end
        end
    end

    initial begin : driver
        bit acc;
        logic [W-1:0] a0, b0, a1, b1;
        bit v0, v1;

        req0_valid = 1; req1_valid = 1;
        repeat (2) @(negedge clk);
        #3;
        check_all_zero("reset");
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        rst = 0;

        send(0, 32'h0000_0140, 32'h0000_00C0);
        send(1, 32'h8000_0000, 32'h0);
        send(1, 32'h1, 32'h2);
        send(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        stall_req = 1;
        send(0, 32'h0000_1000, 32'h0);
        send(0, 32'h0000_0003, 32'h0000_0001);
        send(0, 32'h0000_0003, 32'h0000_0001);

        idle_cycles(30);
        send(1, 32'h8000_0000, 32'h0);
        idle_cycles(2);
        @(negedge clk);
        req0_valid = 1; req1_valid = 1;
        #3;
        rst = 1;
        #1;
        check_all_zero("abort");
        sb.delete();
        outstanding = 0;
        tb_last = 1;
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        rst = 0;

        for (int i = 0; i < 300; i++) begin
            gen(a0, b0); gen(a1, b1);
            drive_cycle(1, a0, b0, 1, a1, b1, acc);
        end
        for (int i = 0; i < 1500; i++) begin
            gen(a0, b0); gen(a1, b1);
            v0 = ($urandom_range(0, 99) < 60);
            v1 = ($urandom_range(0, 99) < 60);
            drive_cycle(v0, a0, b0, v1, a1, b1, acc);
        end

        for (int n = 0; n < 200 && (outstanding || sb.size() != 0); n++)
            idle_cycles(1);
        if (outstanding || sb.size() != 0) chk("drain_timeout", 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
